serial_sub: RTL
===============

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled on each rising clk edge.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits each: minuend and subtrahend, sampled only when start is accepted.
REQ-006 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a new result.
REQ-008 The block SHALL have port diff, output, WIDTH bits: the result a - b modulo 2^WIDTH.
REQ-009 The block SHALL have port borrow, output, 1 bit: high when a < b (unsigned).
REQ-010 The block SHALL have port zero, output, 1 bit: high when diff == 0.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-012 start SHALL be accepted only in IDLE or DONE (busy=0); start in SHIFT SHALL be ignored, with no effect on state, operands or outputs.
REQ-013 On accept at edge N, the block SHALL load a and b into internal shift registers, clear the internal borrow flop and the bit counter, set busy=1 and enter SHIFT.
REQ-014 At each of the WIDTH edges N+1..N+WIDTH, the block SHALL process one bit pair, LSB first: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br); d SHALL shift into the result register from the MSB end; the operand registers SHALL shift right by one.
REQ-015 At edge N+WIDTH, the block SHALL write the completed result to diff, the final borrow to borrow and (result == 0) to zero, set done=1, set busy=0 and enter DONE.
REQ-016 Latency SHALL be exactly WIDTH cycles from the accepting edge to the edge that raises done.
REQ-017 done SHALL be high for exactly one cycle; DONE SHALL return to IDLE on the next edge unless start is high, in which case a new operation SHALL be accepted on that edge (back-to-back, no dead cycle).
REQ-018 diff, borrow and zero SHALL be updated only at completion and SHALL hold their previous values throughout SHIFT and IDLE.
REQ-019 The subtraction SHALL be unsigned with wrap-around: a=0, b=1 yields diff = all ones, borrow=1; a == b yields diff=0, borrow=0, zero=1.
REQ-020 Operand inputs SHALL be don't-care except on the accepting edge; changes to a or b during SHIFT SHALL NOT affect the result.

Reset
REQ-021 rst_n=0 SHALL immediately, independent of clk, force state=IDLE, busy=0, done=0, diff=0, borrow=0, zero=0 and clear all internal registers.
REQ-022 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow, and the first start after rst_n deasserts SHALL be accepted normally.

Verification (WIDTH=8)
REQ-023 a=0x05, b=0x03, start pulse -> done high exactly 8 cycles after accept, diff=0x02, borrow=0, zero=0.
REQ-024 a=0x03, b=0x05 -> diff=0xFE, borrow=1; then a=0x00, b=0x01 -> diff=0xFF, borrow=1.
REQ-025 a=0x7A, b=0x7A -> diff=0x00, borrow=0, zero=1.
REQ-026 Start a=0x10, b=0x01, then pulse start with a=0xFF, b=0x00 at cycle 3 -> second request ignored; result diff=0x0F, a single done pulse.
REQ-027 Start an operation, drop rst_n at cycle 4 -> busy, done, diff, borrow and zero all 0 immediately; no done pulse; next start a=0x09, b=0x04 -> diff=0x05 after 8 cycles.
REQ-028 Hold start high continuously with a=0x20, b=0x01 -> done pulses every 9 cycles, diff=0x1F each time, busy low only in the done cycles.

Source files
------------

// File: rtl/serial_sub.sv
// serial_sub: bit-serial unsigned subtractor, LSB first, one bit per clock, WIDTH-cycle latency
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] ra, rb, res, res_n;
  logic [CW-1:0] cnt;
  logic br, d, br_n, acc, last;
  always_comb begin
    d     = ra[0] ^ rb[0] ^ br;
    br_n  = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
    res_n = {d, res[WIDTH-1:1]};
    acc   = start && state != SHIFT;
    last  = cnt == CW'(WIDTH - 1);
  end
  assign busy = state == SHIFT;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      res    <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
    end else begin
      done <= state == SHIFT && last;
      if (acc) begin
        state <= SHIFT;
        ra    <= a;
        rb    <= b;
        br    <= 1'b0;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        ra  <= ra >> 1;
        rb  <= rb >> 1;
        br  <= br_n;
        res <= res_n;
        cnt <= cnt + 1'b1;
        if (last) begin
          state  <= DONE;
          diff   <= res_n;
          borrow <= br_n;
          zero   <= res_n == '0;
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule
